// File: rtl/ex_pkg.sv
// Shared definitions for the ID/EX operand stage.
//   ALU_*     : 2-bit ALU opcodes carried through alu_control.
//   fwd_sel_e : per-operand forwarding source select.
//   REG_ZERO  : index of the hard-wired zero register (never forwarded or hazarded).
package ex_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one source register.
// Ports:
//   src_i                     : source register index read by the EX instruction
//   reg_data_i                : register-file data captured at ID
//   mem_reg_write_i/rd/result : EX/MEM writeback info
//   wb_reg_write_i/rd/result  : MEM/WB writeback info
//   sel_o                     : chosen source (REG, MEM or WB)
//   data_o                    : forwarded operand value
// The younger MEM result wins over WB; register 0 is never forwarded.
module fwd_unit
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output fwd_sel_e          sel_o,
  output logic [DATA_W-1:0] data_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write_i && (mem_rd_i != REG_AW'(REG_ZERO)) && (mem_rd_i == src_i);
  assign wb_hit  = wb_reg_write_i && (wb_rd_i != REG_AW'(REG_ZERO)) && (wb_rd_i == src_i);

  always_comb begin
    sel_o  = FWD_REG;
    data_o = reg_data_i;
    if (mem_hit) begin
      sel_o  = FWD_MEM;
      data_o = mem_result_i;
    end else if (wb_hit) begin
      sel_o  = FWD_WB;
      data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus operand forwarding into the ALU.
// Ports:
//   clk_i, reset_i         : clock (rising edge), asynchronous active-high reset
//   id_*_i                 : decoded instruction fields from ID
//   flush_i                : squash the instruction being captured
//   ex_hold_i              : downstream stall, freezes the EX register
//   mem_*_i, wb_*_i        : writeback info from EX/MEM and MEM/WB for forwarding
//   id_stall_o             : hold PC and IF/ID (load-use hazard or downstream hold)
//   bus_a_o, bus_b_o       : ALU operands; alu_control_o : ALU opcode
//   ex_valid_o, ex_rd_o    : EX occupancy and destination
//   ex_reg_write_o, ex_mem_read_o, ex_mem_write_o : control, gated by ex_valid_o
//   ex_store_data_o        : forwarded rt value for stores
// Optional macro EX_PERF_CNT_EN adds perf_bubbles_o and perf_fwd_o event counters.
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_alu_src_i,
  input  logic              id_uses_rt_i,
  input  logic [1:0]        id_alu_control_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output logic              id_stall_o,
  output logic [DATA_W-1:0] bus_a_o,
  output logic [DATA_W-1:0] bus_b_o,
  output logic [1:0]        alu_control_o,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic [DATA_W-1:0] ex_store_data_o
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_bubbles_o,
  output logic [31:0]       perf_fwd_o
`endif
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              alu_src_q, alu_src_d;
  logic [1:0]        alu_ctrl_q, alu_ctrl_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic              load_use;
  fwd_sel_e          rs_sel, rt_sel;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // A load in EX whose result is needed by ID cannot be forwarded in time.
  assign load_use = valid_q && mem_read_q && (rd_q != REG_AW'(REG_ZERO)) && id_valid_i &&
                    ((rd_q == id_rs_i) || (id_uses_rt_i && (rd_q == id_rt_i)));

  assign id_stall_o = load_use | ex_hold_i;

  always_comb begin
    valid_d     = valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    alu_ctrl_d  = alu_ctrl_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (ex_hold_i) begin
      // Frozen; a concurrent flush is dropped and must be re-asserted.
    end else if (flush_i || load_use) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      valid_d     = id_valid_i;
      rs_d        = id_rs_i;
      rt_d        = id_rt_i;
      rd_d        = id_rd_i;
      rs_data_d   = id_rs_data_i;
      rt_data_d   = id_rt_data_i;
      imm_d       = id_imm_i;
      alu_src_d   = id_alu_src_i;
      alu_ctrl_d  = id_alu_control_i;
      reg_write_d = id_reg_write_i;
      mem_read_d  = id_mem_read_i;
      mem_write_d = id_mem_write_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= ALU_ADD;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  fwd_unit #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rs (
    .src_i          (rs_q),
    .reg_data_i     (rs_data_q),
    .mem_reg_write_i(mem_reg_write_i),
    .mem_rd_i       (mem_rd_i),
    .mem_result_i   (mem_result_i),
    .wb_reg_write_i (wb_reg_write_i),
    .wb_rd_i        (wb_rd_i),
    .wb_result_i    (wb_result_i),
    .sel_o          (rs_sel),
    .data_o         (rs_fwd)
  );

  fwd_unit #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rt (
    .src_i          (rt_q),
    .reg_data_i     (rt_data_q),
    .mem_reg_write_i(mem_reg_write_i),
    .mem_rd_i       (mem_rd_i),
    .mem_result_i   (mem_result_i),
    .wb_reg_write_i (wb_reg_write_i),
    .wb_rd_i        (wb_rd_i),
    .wb_result_i    (wb_result_i),
    .sel_o          (rt_sel),
    .data_o         (rt_fwd)
  );

  assign bus_a_o         = rs_fwd;
  assign bus_b_o         = alu_src_q ? imm_q : rt_fwd;
  assign ex_store_data_o = rt_fwd;
  assign alu_control_o   = alu_ctrl_q;
  assign ex_valid_o      = valid_q;
  assign ex_rd_o         = rd_q;
  assign ex_reg_write_o  = valid_q & reg_write_q;
  assign ex_mem_read_o   = valid_q & mem_read_q;
  assign ex_mem_write_o  = valid_q & mem_write_q;

`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_fwd_q, perf_fwd_d;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_fwd_d     = perf_fwd_q;
    if (!ex_hold_i && !flush_i && load_use) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
    if (!ex_hold_i && valid_q && ((rs_sel != FWD_REG) || (rt_sel != FWD_REG))) begin
      perf_fwd_d = perf_fwd_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_bubbles_q <= '0;
      perf_fwd_q     <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_fwd_q     <= perf_fwd_d;
    end
  end

  assign perf_bubbles_o = perf_bubbles_q;
  assign perf_fwd_o     = perf_fwd_q;
`else
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^{rs_sel, rt_sel};
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src, id_uses_rt;
  logic [1:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_hold;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        id_stall;
  logic [31:0] bus_a, bus_b, ex_store_data;
  logic [1:0]  alu_control;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  ex_operand_stage #(
    .DATA_W(32),
    .REG_AW(5)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .id_valid_i      (id_valid),
    .id_rs_i         (id_rs),
    .id_rt_i         (id_rt),
    .id_rd_i         (id_rd),
    .id_rs_data_i    (id_rs_data),
    .id_rt_data_i    (id_rt_data),
    .id_imm_i        (id_imm),
    .id_alu_src_i    (id_alu_src),
    .id_uses_rt_i    (id_uses_rt),
    .id_alu_control_i(id_alu_control),
    .id_reg_write_i  (id_reg_write),
    .id_mem_read_i   (id_mem_read),
    .id_mem_write_i  (id_mem_write),
    .flush_i         (flush),
    .ex_hold_i       (ex_hold),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_i        (mem_rd),
    .mem_result_i    (mem_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_result_i     (wb_result),
    .id_stall_o      (id_stall),
    .bus_a_o         (bus_a),
    .bus_b_o         (bus_b),
    .alu_control_o   (alu_control),
    .ex_valid_o      (ex_valid),
    .ex_rd_o         (ex_rd),
    .ex_reg_write_o  (ex_reg_write),
    .ex_mem_read_o   (ex_mem_read),
    .ex_mem_write_o  (ex_mem_write),
    .ex_store_data_o (ex_store_data)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [1:0]  alu;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
  } out_t;

  out_t exp_q[$];
  out_t e, o;
  int   total = 0;
  int   bad = 0;

  function automatic out_t obs();
    out_t r;
    r.valid = ex_valid;
    r.rd    = ex_rd;
    r.alu   = alu_control;
    r.rw    = ex_reg_write;
    r.mr    = ex_mem_read;
    r.mw    = ex_mem_write;
    r.a     = bus_a;
    r.b     = bus_b;
    r.st    = ex_store_data;
    return r;
  endfunction

  function automatic out_t mk(input logic v, input logic [4:0] rd, input logic [1:0] alu,
                              input logic rw, input logic mr, input logic mw,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
    out_t r;
    r.valid = v;
    r.rd    = rd;
    r.alu   = alu;
    r.rw    = v & rw;
    r.mr    = v & mr;
    r.mw    = v & mw;
    r.a     = a;
    r.b     = b;
    r.st    = st;
    return r;
  endfunction

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic src, input logic urt,
                          input logic [1:0] alu, input logic rw, input logic mr,
                          input logic mw);
    id_valid       = v;
    id_rs          = rs;
    id_rt          = rt;
    id_rd          = rd;
    id_rs_data     = rsd;
    id_rt_data     = rtd;
    id_imm         = imm;
    id_alu_src     = src;
    id_uses_rt     = urt;
    id_alu_control = alu;
    id_reg_write   = rw;
    id_mem_read    = mr;
    id_mem_write   = mw;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mw;
    mem_rd        = mrd;
    mem_result    = mres;
    wb_reg_write  = ww;
    wb_rd         = wrd;
    wb_result     = wres;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    flush   = 1'b0;
    ex_hold = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    o = obs();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    total++;
    if (id_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %b want 0", id_stall);
    end
    // ID activity while reset is held must not be captured
    drive_id(1, 1, 2, 3, 32'h5, 32'h6, 32'h7, 1, 1, ALU_SLT, 1, 1, 1);
    tick();
    o = obs();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset_hold_capture: got %h want 0", o);
    end
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    // add r3 = r1 + r2
    drive_id(1, 1, 2, 3, 32'h4, 32'hC, 0, 0, 1, ALU_ADD, 1, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 3, ALU_ADD, 1, 0, 0, 32'h4, 32'hC, 32'hC));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL b2b_add: got %h want %h", o, e);
    end
    // sub r4 = r3 - r1, stale r3 data; add is now in MEM
    drive_id(1, 3, 1, 4, 32'h0, 32'h4, 0, 0, 1, ALU_SUB, 1, 0, 0);
    set_fwd(1, 3, 32'h10, 0, 0, 0);
    #1;
    total++;
    if (id_stall !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_stall: got %b want 0", id_stall);
    end
    exp_q.push_back(mk(1, 4, ALU_SUB, 1, 0, 0, 32'h10, 32'h4, 32'h4));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL b2b_mem_fwd: got %h want %h", o, e);
    end
    // xor r5 = r6 ^ r4; r4 forwarded from WB on the rt side
    drive_id(1, 6, 4, 5, 32'h1, 32'h2, 0, 0, 1, ALU_XOR, 1, 0, 0);
    set_fwd(1, 3, 32'h10, 1, 4, 32'h77);
    exp_q.push_back(mk(1, 5, ALU_XOR, 1, 0, 0, 32'h1, 32'h77, 32'h77));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL b2b_wb_fwd_rt: got %h want %h", o, e);
    end
  endtask

  task automatic test_double_match();
    drive_id(1, 5, 6, 9, 32'h99, 32'h66, 0, 0, 1, ALU_ADD, 1, 0, 0);
    set_fwd(1, 5, 32'hAAAA, 1, 5, 32'h5555);
    exp_q.push_back(mk(1, 9, ALU_ADD, 1, 0, 0, 32'hAAAA, 32'h66, 32'h66));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL double_mem_wins: got %h want %h", o, e);
    end
    // register 0 must never be forwarded
    drive_id(1, 0, 0, 9, 32'h0, 32'h0, 0, 0, 1, ALU_ADD, 1, 0, 0);
    set_fwd(1, 0, 32'hAAAA, 1, 0, 32'h5555);
    exp_q.push_back(mk(1, 9, ALU_ADD, 1, 0, 0, 32'h0, 32'h0, 32'h0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL double_r0_noforward: got %h want %h", o, e);
    end
    // MEM not writing: WB match is used
    drive_id(1, 5, 5, 9, 32'h99, 32'h99, 0, 0, 1, ALU_ADD, 1, 0, 0);
    set_fwd(0, 5, 32'hAAAA, 1, 5, 32'h5555);
    exp_q.push_back(mk(1, 9, ALU_ADD, 1, 0, 0, 32'h5555, 32'h5555, 32'h5555));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL double_wb_only: got %h want %h", o, e);
    end
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    // lw r7, 4(r1)
    drive_id(1, 1, 0, 7, 32'h100, 32'h0, 32'h4, 1, 0, ALU_ADD, 1, 1, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 7, ALU_ADD, 1, 1, 0, 32'h100, 32'h4, 32'h0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL lu_load: got %h want %h", o, e);
    end
    // add r8 = r7 + r2
    drive_id(1, 7, 2, 8, 32'h0, 32'h3, 0, 0, 1, ALU_ADD, 1, 0, 0);
    #1;
    total++;
    if (id_stall !== 1'b1) begin
      bad++;
      $display("FAIL lu_stall: got %b want 1", id_stall);
    end
    exp_q.push_back(mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if ({o.valid, o.rw, o.mr, o.mw} !== {e.valid, e.rw, e.mr, e.mw}) begin
      bad++;
      $display("FAIL lu_bubble: got %b want %b", {o.valid, o.rw, o.mr, o.mw},
               {e.valid, e.rw, e.mr, e.mw});
    end
    total++;
    if (id_stall !== 1'b0) begin
      bad++;
      $display("FAIL lu_stall_released: got %b want 0", id_stall);
    end
    // load now in WB
    set_fwd(0, 0, 0, 1, 7, 32'h1234);
    exp_q.push_back(mk(1, 8, ALU_ADD, 1, 0, 0, 32'h1234, 32'h3, 32'h3));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL lu_wb_fwd: got %h want %h", o, e);
    end
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use_rt();
    // lw r9
    drive_id(1, 1, 0, 9, 32'h40, 32'h0, 32'h8, 1, 0, ALU_ADD, 1, 1, 0);
    exp_q.push_back(mk(1, 9, ALU_ADD, 1, 1, 0, 32'h40, 32'h8, 32'h0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL lurt_load: got %h want %h", o, e);
    end
    drive_id(1, 2, 9, 10, 32'h1, 32'h2, 0, 0, 0, ALU_ADD, 1, 0, 0);
    #1;
    total++;
    if (id_stall !== 1'b0) begin
      bad++;
      $display("FAIL lurt_rt_unused: got %b want 0", id_stall);
    end
    id_uses_rt = 1'b1;
    #1;
    total++;
    if (id_stall !== 1'b1) begin
      bad++;
      $display("FAIL lurt_rt_used: got %b want 1", id_stall);
    end
    id_valid = 1'b0;
    #1;
    total++;
    if (id_stall !== 1'b0) begin
      bad++;
      $display("FAIL lurt_id_invalid: got %b want 0", id_stall);
    end
    ex_hold = 1'b1;
    #1;
    total++;
    if (id_stall !== 1'b1) begin
      bad++;
      $display("FAIL lurt_hold_stall: got %b want 1", id_stall);
    end
    ex_hold = 1'b0;
    // load into r0 never creates a hazard
    drive_id(1, 1, 0, 0, 32'h40, 32'h0, 32'h8, 1, 0, ALU_ADD, 1, 1, 0);
    exp_q.push_back(mk(1, 0, ALU_ADD, 1, 1, 0, 32'h40, 32'h8, 32'h0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL lurt_load_r0: got %h want %h", o, e);
    end
    drive_id(1, 0, 0, 3, 32'h0, 32'h0, 0, 0, 1, ALU_ADD, 1, 0, 0);
    #1;
    total++;
    if (id_stall !== 1'b0) begin
      bad++;
      $display("FAIL lurt_r0_no_stall: got %b want 0", id_stall);
    end
  endtask

  task automatic test_imm_path();
    // sw r6, -4(r3): rt forwarded from MEM, bus_b takes the immediate
    drive_id(1, 3, 6, 6, 32'h5, 32'h1, 32'hFFFF_FFFC, 1, 1, ALU_ADD, 0, 0, 1);
    set_fwd(1, 6, 32'hBEEF, 0, 0, 0);
    exp_q.push_back(mk(1, 6, ALU_ADD, 0, 0, 1, 32'h5, 32'hFFFF_FFFC, 32'hBEEF));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL imm_path: got %h want %h", o, e);
    end
    set_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_priority();
    out_t x;
    x = mk(1, 4, ALU_SLT, 1, 0, 0, 32'h11, 32'h22, 32'h22);
    drive_id(1, 2, 3, 4, 32'h11, 32'h22, 0, 0, 1, ALU_SLT, 1, 0, 0);
    exp_q.push_back(x);
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL prio_capture: got %h want %h", o, e);
    end
    // flush and hold together: frozen
    drive_id(1, 5, 6, 7, 32'h33, 32'h44, 0, 0, 1, ALU_XOR, 0, 0, 1);
    flush   = 1'b1;
    ex_hold = 1'b1;
    exp_q.push_back(x);
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL prio_flush_hold: got %h want %h", o, e);
    end
    flush = 1'b0;
    exp_q.push_back(x);
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL prio_hold: got %h want %h", o, e);
    end
    ex_hold = 1'b0;
    // flush alone on a hazard-free instruction
    flush = 1'b1;
    exp_q.push_back(mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if ({o.valid, o.rw, o.mr, o.mw} !== {e.valid, e.rw, e.mr, e.mw}) begin
      bad++;
      $display("FAIL prio_flush: got %b want %b", {o.valid, o.rw, o.mr, o.mw},
               {e.valid, e.rw, e.mr, e.mw});
    end
    flush = 1'b0;
    // flush during load-use
    drive_id(1, 1, 0, 7, 32'h100, 32'h0, 32'h4, 1, 0, ALU_ADD, 1, 1, 0);
    exp_q.push_back(mk(1, 7, ALU_ADD, 1, 1, 0, 32'h100, 32'h4, 32'h0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL prio_load: got %h want %h", o, e);
    end
    drive_id(1, 7, 2, 8, 32'h0, 32'h3, 0, 0, 1, ALU_ADD, 1, 0, 0);
    flush = 1'b1;
    exp_q.push_back(mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front();
    o = obs();
    total++;
    if ({o.valid, o.rw, o.mr, o.mw} !== {e.valid, e.rw, e.mr, e.mw}) begin
      bad++;
      $display("FAIL prio_flush_lu: got %b want %b", {o.valid, o.rw, o.mr, o.mw},
               {e.valid, e.rw, e.mr, e.mw});
    end
    flush = 1'b0;
    // async reset mid-cycle while stalled
    drive_id(1, 1, 0, 7, 32'h100, 32'h0, 32'h4, 1, 0, ALU_ADD, 1, 1, 0);
    tick();
    drive_id(1, 7, 2, 8, 32'h0, 32'h3, 0, 0, 1, ALU_ADD, 1, 0, 0);
    #1;
    total++;
    if (id_stall !== 1'b1) begin
      bad++;
      $display("FAIL prio_pre_reset_stall: got %b want 1", id_stall);
    end
    #2;
    reset = 1'b1;
    #1;
    o = obs();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL async_reset_outputs: got %h want 0", o);
    end
    total++;
    if (id_stall !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_stall: got %b want 0", id_stall);
    end
    #1;
    reset = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_double_match();
    test_load_use();
    test_load_use_rt();
    test_imm_path();
    test_priority();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
